data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//   Single-port data memory behind a fixed-latency request/acknowledge
//   handshake. Supports byte/half/word/dword accesses at any byte lane, with
//   sign- or zero-extension of load results. Each access takes
//   WAIT_STATES+2 cycles: accept (IDLE), WAIT_STATES wait cycles, one RESP
//   cycle carrying ack.
//
//   Optional feature macro: DMEM_ERR_CHECK_EN
//     defined   : misaligned, out-of-range and unsupported-size accesses raise
//                 err with ack, suppress the write and return 0.
//     undefined : err is tied low; index is truncated, low address bits are
//                 aligned down, and dword on a 32-bit memory acts as word.
//
// Ports
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset (memory contents kept)
//   req         : request valid, sampled only while idle
//   we          : 1 = store, 0 = load
//   size        : 0 byte, 1 half, 2 word, 3 dword
//   sign_ext    : 1 = sign-extend load data, 0 = zero-extend
//   address     : byte address
//   write_data  : store data, taken from the low lanes
//   busy        : high whenever a request would not be accepted
//   ack         : one-cycle completion pulse
//   err         : access error, meaningful only while ack is high
//   read_data   : extended load result, held until the next load completes
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 64,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Low-address mask that must be zero for an access of the given size.
  function automatic logic [2:0] low_mask(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;

  // ---------------------------------------------------------------------------
  // Active request view. With WAIT_STATES=0 the access completes on the very
  // edge that accepts it, before the request registers have loaded, so while
  // idle the live inputs describe the access; afterwards the registered copy.
  // ---------------------------------------------------------------------------
  logic                  in_idle;
  logic                  act_we;
  logic [1:0]            act_size;
  logic                  act_sext;
  logic [ADDR_WIDTH-1:0] act_addr;
  logic [DATA_WIDTH-1:0] act_wdata;

  assign in_idle   = (state_q == IDLE);
  assign act_we    = in_idle ? we         : we_q;
  assign act_size  = in_idle ? size       : size_q;
  assign act_sext  = in_idle ? sign_ext   : sext_q;
  assign act_addr  = in_idle ? address    : addr_q;
  assign act_wdata = in_idle ? write_data : wdata_q;

  // ---------------------------------------------------------------------------
  // Address decode and lane handling
  // ---------------------------------------------------------------------------
  logic [1:0]            size_eff;
  logic [2:0]            eff_mask;
  logic [OFF_W-1:0]      lane_al;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] key;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [DATA_WIDTH-1:0] new_word;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] val_mask;
  logic [DATA_WIDTH-1:0] rd_ext;
  logic                  sbit;
  logic                  misalign;
  logic                  out_of_range;
  logic                  unsupported;
  logic                  access_err;

  assign size_eff     = (DATA_WIDTH == 32 && act_size == 2'd3) ? 2'd2 : act_size;
  assign eff_mask     = low_mask(size_eff);
  assign lane_al      = act_addr[OFF_W-1:0] & ~eff_mask[OFF_W-1:0];
  assign mem_idx      = act_addr[OFF_W +: IDX_W];
  assign misalign     = |(act_addr[2:0] & low_mask(act_size));
  assign out_of_range = |(act_addr >> (OFF_W + IDX_W));
  assign unsupported  = (DATA_WIDTH == 32) && (act_size == 2'd3);

  // The array stores data XOR word index, so an array that powers up all-zero
  // reads back as word i = i without any initialisation logic.
  assign key      = DATA_WIDTH'(mem_idx);
  assign old_word = mem_q[mem_idx] ^ key;

  always_comb begin
    int lane;
    int nbytes;
    lane     = int'(lane_al);
    nbytes   = 1 << size_eff;
    bit_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      bit_mask[8*b +: 8] = (b >= lane && b < lane + nbytes) ? 8'hFF : 8'h00;
    end
    new_word = (old_word & ~bit_mask) | ((act_wdata << (8 * lane)) & bit_mask);
    rd_shift = old_word >> (8 * lane);
    // Shifting all-ones by the full width yields 0, so a full-width access
    // gets an all-ones value mask without a special case.
    val_mask = ~({DATA_WIDTH{1'b1}} << (8 * nbytes));
    sbit     = |(rd_shift & val_mask & ~(val_mask >> 1));
    rd_ext   = (rd_shift & val_mask) | ((act_sext && sbit) ? ~val_mask : '0);
  end

`ifdef DMEM_ERR_CHECK_EN
  assign access_err = misalign | out_of_range | unsupported;
`else
  assign access_err = 1'b0;
  logic unused_err_terms;
  assign unused_err_terms = misalign ^ out_of_range ^ unsupported;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state, request capture and access completion
  // ---------------------------------------------------------------------------
  logic accept;
  logic complete;

  // NOTE: every signal gets a default before the case so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    sext_d   = sext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    accept   = 1'b0;
    complete = 1'b0;
    mem_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d  = RESP;
            complete = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = RESP;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      we_d    = we;
      size_d  = size;
      sext_d  = sign_ext;
      addr_d  = address;
      wdata_d = write_data;
    end

    // Memory update and load capture happen on the edge entering RESP.
    if (complete) begin
      err_d = access_err;
      if (access_err) begin
        rdata_d = '0;
      end else if (act_we) begin
        mem_we = 1'b1;
      end else begin
        rdata_d = rd_ext;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array has no reset; reset must leave its contents intact,
  // and an aborted transaction never reaches the write enable above.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_idx] <= new_word ^ key;
    end
  end

  assign busy      = !in_idle;
  assign ack       = (state_q == RESP);
  assign err       = ack & err_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
//   Directed bench for data_memory_ctrl. Main instance uses the default
//   parameters (64-bit data, 64 words, 2 wait states); a second instance with
//   WAIT_STATES=0 covers back-to-back throughput. Error checks follow the
//   DMEM_ERR_CHECK_EN build option.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  always #5 clock = ~clock;

  // Main instance, WAIT_STATES = 2
  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [63:0] address, write_data, read_data;
  logic        busy, ack, err;

  // Zero-wait-state instance
  logic        req0, we0, sext0;
  logic [1:0]  size0;
  logic [63:0] address0, wdata0, read_data0;
  logic        busy0, ack0, err0;

  data_memory_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .we         (we),
    .size       (size),
    .sign_ext   (sign_ext),
    .address    (address),
    .write_data (write_data),
    .busy       (busy),
    .ack        (ack),
    .err        (err),
    .read_data  (read_data)
  );

  data_memory_ctrl #(.WAIT_STATES(0)) dut0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req0),
    .we         (we0),
    .size       (size0),
    .sign_ext   (sext0),
    .address    (address0),
    .write_data (wdata0),
    .busy       (busy0),
    .ack        (ack0),
    .err        (err0),
    .read_data  (read_data0)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // One access on the main instance. Called at a negedge with the DUT idle;
  // returns at a negedge after ack has dropped. Inputs are scrambled after the
  // accept edge to show they are not looked at again.
  task automatic access(input string tag, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic e, output int lat);
    int guard;
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    req = 1'b1; we = w; size = sz; sign_ext = sx; address = a; write_data = wd;
    @(posedge clock);
    lat = 0; e = 1'b0; rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 1) begin
        req = 1'b0; we = ~w; size = ~sz; sign_ext = ~sx;
        address = ~a; write_data = ~wd;
      end
      if (ack) begin
        lat = n;
        e   = err;
        rd  = read_data;
        break;
      end
    end
    if (lat == 0) check({tag, "_ack_timeout"}, 64'd0, 64'd1);
    @(negedge clock);
    check({tag, "_ack_pulse"}, 64'(ack), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [63:0] rd;
    logic        e;
    int          lat;
    int          acks;

    req = 0; we = 0; size = 0; sign_ext = 0; address = 0; write_data = 0;
    req0 = 0; we0 = 0; size0 = 0; sext0 = 0; address0 = 0; wdata0 = 0;

    // Reset values while reset is held
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", read_data, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Dword read of initial word 5
    access("rd28", 1'b0, 2'd3, 1'b0, 64'h28, 64'h0, rd, e, lat);
    check("rd28_lat", 64'(lat), 64'd3);
    check("rd28_err", 64'(e), 64'd0);
    check("rd28_data", rd, 64'h5);

    // Byte store into lane 1 of word 2; load result must stay at 5
    access("wrb11", 1'b1, 2'd0, 1'b0, 64'h11, 64'h1234_5678_9ABC_DEAB, rd, e, lat);
    check("wrb11_lat", 64'(lat), 64'd3);
    check("wrb11_err", 64'(e), 64'd0);
    check("wrb11_rdata_held", rd, 64'h5);

    access("rd10", 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, e, lat);
    check("rd10_data", rd, 64'h0000_0000_0000_AB02);

    access("rdb11_s", 1'b0, 2'd0, 1'b1, 64'h11, 64'h0, rd, e, lat);
    check("rdb11_sext", rd, 64'hFFFF_FFFF_FFFF_FFAB);
    access("rdb11_z", 1'b0, 2'd0, 1'b0, 64'h11, 64'h0, rd, e, lat);
    check("rdb11_zext", rd, 64'h0000_0000_0000_00AB);

    // Half store into lanes 2..3 of word 3
    access("wrh1a", 1'b1, 2'd1, 1'b0, 64'h1A, 64'h1234_BEEF, rd, e, lat);
    access("rdw18", 1'b0, 2'd2, 1'b1, 64'h18, 64'h0, rd, e, lat);
    check("rdw18_sext", rd, 64'hFFFF_FFFF_BEEF_0003);
    access("rdh1a", 1'b0, 2'd1, 1'b0, 64'h1A, 64'h0, rd, e, lat);
    check("rdh1a_zext", rd, 64'h0000_0000_0000_BEEF);
    access("rdw1c", 1'b0, 2'd2, 1'b1, 64'h1C, 64'h0, rd, e, lat);
    check("rdw1c_upper", rd, 64'h0);

    // Full dword store, then upper-word signed load and full readback
    access("wrd38", 1'b1, 2'd3, 1'b0, 64'h38, 64'h8000_0000_0000_0001, rd, e, lat);
    access("rdw3c", 1'b0, 2'd2, 1'b1, 64'h3C, 64'h0, rd, e, lat);
    check("rdw3c_sext", rd, 64'hFFFF_FFFF_8000_0000);
    access("rdd38", 1'b0, 2'd3, 1'b0, 64'h38, 64'h0, rd, e, lat);
    check("rdd38_data", rd, 64'h8000_0000_0000_0001);

    // Reset asserted while a write sits in WAIT
    req = 1'b1; we = 1'b1; size = 2'd3; sign_ext = 1'b0;
    address = 64'h30; write_data = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    check("mid_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ack", 64'(ack), 64'd0);
    check("abort_rdata", read_data, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    access("rd30", 1'b0, 2'd3, 1'b0, 64'h30, 64'h0, rd, e, lat);
    check("rd30_unchanged", rd, 64'h6);
    check("rd30_lat", 64'(lat), 64'd3);

`ifdef DMEM_ERR_CHECK_EN
    access("wrh13", 1'b1, 2'd1, 1'b0, 64'h13, 64'h7777, rd, e, lat);
    check("wrh13_err", 64'(e), 64'd1);
    check("wrh13_lat", 64'(lat), 64'd3);
    access("rd10b", 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, e, lat);
    check("rd10b_err", 64'(e), 64'd0);
    check("rd10b_data", rd, 64'h0000_0000_0000_AB02);
    access("rd200", 1'b0, 2'd3, 1'b0, 64'h200, 64'h0, rd, e, lat);
    check("rd200_err", 64'(e), 64'd1);
    check("rd200_data", rd, 64'h0);
`else
    // Misaligned half store lands on the aligned lanes 2..3
    access("wrh13", 1'b1, 2'd1, 1'b0, 64'h13, 64'h7777, rd, e, lat);
    check("wrh13_err", 64'(e), 64'd0);
    access("rd10b", 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, e, lat);
    check("rd10b_data", rd, 64'h0000_0000_7777_AB02);
    // Word index 65 wraps to word 1
    access("rd208", 1'b0, 2'd3, 1'b0, 64'h208, 64'h0, rd, e, lat);
    check("rd208_err", 64'(e), 64'd0);
    check("rd208_data", rd, 64'h1);
    // Misaligned word load reads from 0x18
    access("rdw1b", 1'b0, 2'd2, 1'b0, 64'h1B, 64'h0, rd, e, lat);
    check("rdw1b_data", rd, 64'h0000_0000_BEEF_0003);
`endif

    // Zero-wait-state instance: req held high accepts every second cycle
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; size0 = 2'd3; sext0 = 1'b0; address0 = 64'h8; wdata0 = 64'h0;
    acks = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      check($sformatf("b2b_busy_%0d", n), 64'(busy0), 64'(n % 2));
      if (ack0) acks++;
    end
    req0 = 1'b0;
    check("b2b_ack_count", 64'(acks), 64'd4);
    check("b2b_rdata", read_data0, 64'h1);
    @(negedge clock);

    // Zero-wait write uses live inputs on the accepting edge
    req0 = 1'b1; we0 = 1'b1; size0 = 2'd2; address0 = 64'h4; wdata0 = 64'hFFFF_FFFF_1234_5678;
    @(negedge clock);
    check("ws0_wr_ack", 64'(ack0), 64'd1);
    req0 = 1'b0;
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; size0 = 2'd3; address0 = 64'h0;
    @(negedge clock);
    check("ws0_rd_ack", 64'(ack0), 64'd1);
    check("ws0_rd_data", read_data0, 64'h1234_5678_0000_0000);
    req0 = 1'b0;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
